hazard_control: RTL and testbench
=================================

# hazard_control

Stall/flush controller for the 5-stage MIPS pipeline, the stalling counterpart of the forwarding path. It covers the hazards that forwarding cannot resolve. On a load-use dependency it holds PC and IF/ID and injects a one-cycle ID/EX bubble. On a branch taken in ID it flushes IF/ID. While the data memory has not acknowledged an access in MEM, it freezes the whole pipeline, counts wait cycles and flags a timeout. It sits beside the ID stage, is driven from the ID/EX and EX/MEM pipeline registers, and gates their write enables.

## Interface
- TIMEOUT, default 16: number of memory wait cycles after which MemTimeout is set. Legal range 1..255.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IDEXMemRead  in  1  instruction in EX is a load.
- IDEXRegisterRt  in  5  load destination register.
- IFIDRegisterRs  in  5  Rs of the instruction in ID.
- IFIDRegisterRt  in  5  Rt of the instruction in ID.
- IFIDUsesRt  in  1  the instruction in ID reads Rt (R-type, store, beq/bne).
- BranchTaken  in  1  branch resolved taken in ID this cycle.
- EXMEMMemRead  in  1  load in MEM.
- EXMEMMemWrite  in  1  store in MEM.
- DMemReady  in  1  data memory completes the MEM access this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID write enable.
- IFIDFlush  out  1  clear IF/ID to nop.
- IDEXBubble  out  1  zero ID/EX control fields.
- PipeFreeze  out  1  hold ID/EX, EX/MEM and MEM/WB, and bubble MEM/WB RegWrite.
- MemTimeout  out  1  sticky wait-timeout flag.
- WaitCount  out  8  wait cycles of the current or last memory access.

## Operation
- LoadUse = IDEXMemRead & (IDEXRegisterRt!=0) & ((IDEXRegisterRt==IFIDRegisterRs) | (IFIDUsesRt & (IDEXRegisterRt==IFIDRegisterRt))).
- MemBusy = (EXMEMMemRead | EXMEMMemWrite) & ~DMemReady.
- The FSM has two states, RUN and WAIT.
- RUN:
  - If MemBusy: assert PipeFreeze, deassert PCWrite and IFIDWrite, set WaitCount=1, go to WAIT.
  - Else if LoadUse: PCWrite=0, IFIDWrite=0, IDEXBubble=1, stay in RUN. The condition self-clears next cycle once the load moves into MEM.
  - Else if BranchTaken: IFIDFlush=1.
  - Otherwise all enables are 1 and all bubbles/flushes are 0.
- WAIT:
  - While ~DMemReady: keep the freeze outputs active and increment WaitCount, saturating at 255.
  - When WaitCount reaches TIMEOUT, set MemTimeout and keep waiting.
  - On DMemReady: release the freeze in that same cycle, evaluate LoadUse/BranchTaken as in RUN, and go to RUN. WaitCount holds its value.
- Priority: freeze > load-use > flush. While frozen, IDEXBubble=0 and IFIDFlush=0; the held instructions re-evaluate once the freeze releases.
- A simultaneous LoadUse and BranchTaken gives a stall with no flush, because the branch operand is not yet valid.
- MemTimeout is cleared only by reset.

## Timing
- All outputs are combinational from the state register and the current inputs (Mealy). State, WaitCount and MemTimeout update on rising clk.
- Reset: state=RUN, WaitCount=0, MemTimeout=0. While reset is high, outputs are forced to PCWrite=1, IFIDWrite=1 and IFIDFlush=IDEXBubble=PipeFreeze=0, regardless of inputs.
- Reset asserted mid-WAIT aborts the wait immediately and asynchronously.
- Load-use costs exactly 1 cycle. A memory wait costs N frozen cycles, where N is the number of cycles before DMemReady.
- A zero-wait access (DMemReady high in the first cycle) never leaves RUN.

## Configuration
- HAZARD_STATS_EN defined: adds outputs StallCount[31:0] and FlushCount[31:0].
  - StallCount increments on every cycle with PCWrite=0; FlushCount increments on every IFIDFlush cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent, and the block's behaviour is otherwise identical.

## Structure
- Shared package haz_pkg holds the state encoding (RUN=1'b0, WAIT=1'b1), the default TIMEOUT and the width constant WAIT_W=8.
- One sub-module, hazard_wait_timer, holds the saturating WaitCount and the MemTimeout compare.
  - Inputs: start, tick, clear.
  - Outputs: WaitCount, MemTimeout.

## Test plan
- lw $5 in EX and add using Rs=5 in ID -> one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1, then normal operation. With IDEXRegisterRt=0 -> no stall.
- Load in EX with Rt=7, ID Rt=7, IFIDUsesRt=0 -> no stall; with IFIDUsesRt=1 -> stall.
- BranchTaken=1 with no hazard -> IFIDFlush=1 for exactly that cycle. BranchTaken together with LoadUse -> stall, IFIDFlush=0.
- Store in MEM with DMemReady low for 3 cycles -> PipeFreeze high for 3 cycles, WaitCount=3, release on the ready cycle, MemTimeout=0.
- TIMEOUT=4, DMemReady held low for 10 cycles -> MemTimeout rises at WaitCount=4 and stays high after release until reset. Asserting reset mid-wait -> PipeFreeze=0 immediately.
- With HAZARD_STATS_EN: 2 load-use stalls + 3 frozen cycles + 1 flush -> StallCount=5, FlushCount=1.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default memory-wait timeout and the wait-counter width.
package haz_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hazState_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int WAIT_W      = 8;

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating memory-wait cycle counter with a sticky timeout flag.
// 'clear' is the asynchronous reset; WaitCount holds when neither start nor tick.
module hazard_wait_timer
    import haz_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              tick,
    output logic [WAIT_W-1:0] WaitCount,
    output logic              MemTimeout
);

    logic [WAIT_W-1:0] nextCount;

    always_comb begin
        nextCount = WaitCount;
        if (start)
            nextCount = WAIT_W'(1);
        else if (tick && (WaitCount != '1))
            nextCount = WaitCount + WAIT_W'(1);
    end

    // Flag rises on the same edge the count lands on TIMEOUT.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            WaitCount  <= '0;
            MemTimeout <= 1'b0;
        end else begin
            WaitCount <= nextCount;
            if ((start || tick) && (nextCount == WAIT_W'(TIMEOUT)))
                MemTimeout <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Stall/flush controller for the 5-stage pipeline: load-use stall, branch flush,
// data-memory wait freeze. Define HAZARD_STATS_EN to add stall/flush counters.
module hazard_control
    import haz_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IDEXMemRead,
    input  logic [4:0]        IDEXRegisterRt,
    input  logic [4:0]        IFIDRegisterRs,
    input  logic [4:0]        IFIDRegisterRt,
    input  logic              IFIDUsesRt,
    input  logic              BranchTaken,
    input  logic              EXMEMMemRead,
    input  logic              EXMEMMemWrite,
    input  logic              DMemReady,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IFIDFlush,
    output logic              IDEXBubble,
    output logic              PipeFreeze,
    output logic              MemTimeout,
    output logic [WAIT_W-1:0] WaitCount
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    hazState_t state, nextState;
    logic loadUse, memBusy, released;
    logic timerStart, timerTick;

    assign loadUse = IDEXMemRead && (IDEXRegisterRt != 5'd0) &&
                     ((IDEXRegisterRt == IFIDRegisterRs) ||
                      (IFIDUsesRt && (IDEXRegisterRt == IFIDRegisterRt)));
    assign memBusy = (EXMEMMemRead || EXMEMMemWrite) && !DMemReady;

    // Pipeline runs when RUN sees no busy access, or WAIT sees the ready.
    assign released = (state == RUN) ? !memBusy : DMemReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= nextState;
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        PipeFreeze = 1'b0;
        timerStart = 1'b0;
        timerTick  = 1'b0;
        nextState  = state;
        if (!reset) begin
            if (!released) begin
                PipeFreeze = 1'b1;
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                timerStart = (state == RUN);
                timerTick  = (state == WAIT);
                nextState  = WAIT;
            end else begin
                nextState = RUN;
                // Load-use wins over a taken branch: its operand is not ready yet.
                if (loadUse) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end else if (BranchTaken) begin
                    IFIDFlush = 1'b1;
                end
            end
        end
    end

    hazard_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
        .clk       (clk),
        .clear     (reset),
        .start     (timerStart),
        .tick      (timerTick),
        .WaitCount (WaitCount),
        .MemTimeout(MemTimeout)
    );

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PCWrite && (StallCount != '1)) StallCount <= StallCount + 32'd1;
            if (IFIDFlush && (FlushCount != '1)) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed scoreboard bench for hazard_control (TIMEOUT=4); checks counters
// too when HAZARD_STATS_EN is defined.
module tb_hazard_control;

    logic clk = 1'b0;
    logic reset;
    logic IDEXMemRead, IFIDUsesRt, BranchTaken, EXMEMMemRead, EXMEMMemWrite, DMemReady;
    logic [4:0] IDEXRegisterRt, IFIDRegisterRs, IFIDRegisterRt;
    logic PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze, MemTimeout;
    logic [7:0] WaitCount;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCount, FlushCount;
`endif

    int nAssert = 0;
    int nFail   = 0;

    typedef struct {
        logic pcw, ifidw, flush, bubble, freeze, to;
        logic [7:0]  wc;
        logic [31:0] st, fl;
    } exp_t;

    exp_t sb[$];
    logic [31:0] modelStall = 0, modelFlush = 0;

    always #5 clk = ~clk;

    hazard_control #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .IDEXMemRead   (IDEXMemRead),
        .IDEXRegisterRt(IDEXRegisterRt),
        .IFIDRegisterRs(IFIDRegisterRs),
        .IFIDRegisterRt(IFIDRegisterRt),
        .IFIDUsesRt    (IFIDUsesRt),
        .BranchTaken   (BranchTaken),
        .EXMEMMemRead  (EXMEMMemRead),
        .EXMEMMemWrite (EXMEMMemWrite),
        .DMemReady     (DMemReady),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXBubble    (IDEXBubble),
        .PipeFreeze    (PipeFreeze),
        .MemTimeout    (MemTimeout),
        .WaitCount     (WaitCount)
`ifdef HAZARD_STATS_EN
        ,
        .StallCount    (StallCount),
        .FlushCount    (FlushCount)
`endif
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare at negedge.
    task automatic step(input string tag,
                        input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic br,
                        input logic mrd, input logic mwr, input logic rdy,
                        input logic pcw, input logic ifidw, input logic fl,
                        input logic bub, input logic frz, input logic to,
                        input logic [7:0] wc);
        exp_t e, g;
        IDEXMemRead = mr;  IDEXRegisterRt = xrt; IFIDRegisterRs = rs;
        IFIDRegisterRt = rt; IFIDUsesRt = ur; BranchTaken = br;
        EXMEMMemRead = mrd; EXMEMMemWrite = mwr; DMemReady = rdy;
        if (reset) begin modelStall = 0; modelFlush = 0; end
        e.pcw = pcw; e.ifidw = ifidw; e.flush = fl; e.bubble = bub;
        e.freeze = frz; e.to = to; e.wc = wc; e.st = modelStall; e.fl = modelFlush;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        cmp({tag, ".PCWrite"},    {31'd0, PCWrite},    {31'd0, g.pcw});
        cmp({tag, ".IFIDWrite"},  {31'd0, IFIDWrite},  {31'd0, g.ifidw});
        cmp({tag, ".IFIDFlush"},  {31'd0, IFIDFlush},  {31'd0, g.flush});
        cmp({tag, ".IDEXBubble"}, {31'd0, IDEXBubble}, {31'd0, g.bubble});
        cmp({tag, ".PipeFreeze"}, {31'd0, PipeFreeze}, {31'd0, g.freeze});
        cmp({tag, ".MemTimeout"}, {31'd0, MemTimeout}, {31'd0, g.to});
        cmp({tag, ".WaitCount"},  {24'd0, WaitCount},  {24'd0, g.wc});
`ifdef HAZARD_STATS_EN
        cmp({tag, ".StallCount"}, StallCount, g.st);
        cmp({tag, ".FlushCount"}, FlushCount, g.fl);
`endif
        @(posedge clk);
        #1;
        if (!reset) begin
            if (!pcw) modelStall++;
            if (fl)   modelFlush++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        // Hazardous inputs during reset: outputs must stay in the pass-through state.
        step("rst", 1, 5'd5, 5'd5, 0, 0, 1, 1, 0, 0,  1,1,0,0,0,0,8'd0);
        reset = 1'b0;
        step("idle",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1,1,0,0,0,0,8'd0);
        step("lwuse",  1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0, 1,  0,0,0,1,0,0,8'd0);
        step("lwmem0", 0, 5'd0, 5'd5, 5'd2, 0, 0, 1, 0, 1,  1,1,0,0,0,0,8'd0);
        step("rt0",    1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1,  1,1,0,0,0,0,8'd0);
        step("rtnouse",1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 1,  1,1,0,0,0,0,8'd0);
        step("rtuse",  1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 1,  0,0,0,1,0,0,8'd0);
        step("branch", 0, 5'd0, 5'd3, 5'd4, 1, 1, 0, 0, 1,  1,1,1,0,0,0,8'd0);
        step("brlu",   1, 5'd9, 5'd9, 5'd4, 1, 1, 0, 0, 1,  0,0,0,1,0,0,8'd0);
        step("idle2",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1,1,0,0,0,0,8'd0);
        // Store waits three cycles; load-use inputs during the freeze get no bubble.
        step("st1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  0,0,0,0,1,0,8'd0);
        step("st2",    1, 5'd6, 5'd6, 5'd0, 0, 1, 0, 1, 0,  0,0,0,0,1,0,8'd1);
        step("st3",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  0,0,0,0,1,0,8'd2);
        step("strel",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1,  1,1,1,0,0,0,8'd3);
        step("sthold", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1,1,0,0,0,0,8'd3);
        // Load waits ten cycles: timeout rises once WaitCount reaches 4.
        step("to1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0,  0,0,0,0,1,0,8'd3);
        for (int k = 2; k <= 10; k++)
            step($sformatf("to%0d", k), 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0,
                 0,0,0,0,1, (k - 1 >= 4), 8'(k - 1));
        step("torel",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1,  1,1,0,0,0,1,8'd10);
        step("tohold", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1,1,0,0,0,1,8'd10);
        // Start another wait, then abort it with a mid-cycle reset.
        step("ab1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0,  0,0,0,0,1,1,8'd10);
        step("ab2",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0,  0,0,0,0,1,1,8'd1);
        reset = 1'b1;
        step("abrst",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0,  1,1,0,0,0,0,8'd0);
        reset = 1'b0;
        step("post",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1,1,0,0,0,0,8'd0);
`ifdef HAZARD_STATS_EN
        // Two load-use stalls, three frozen cycles and one flush.
        step("s_lu1",  1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 1,  0,0,0,1,0,0,8'd0);
        step("s_lu2",  1, 5'd8, 5'd1, 5'd8, 1, 0, 0, 0, 1,  0,0,0,1,0,0,8'd0);
        step("s_f1",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  0,0,0,0,1,0,8'd0);
        step("s_f2",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  0,0,0,0,1,0,8'd1);
        step("s_f3",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  0,0,0,0,1,0,8'd2);
        step("s_rel",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1,  1,1,0,0,0,0,8'd3);
        step("s_br",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1,  1,1,1,0,0,0,8'd3);
        step("s_end",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1,1,0,0,0,0,8'd3);
        cmp("statsStall", StallCount, 32'd5);
        cmp("statsFlush", FlushCount, 32'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
